// File: rtl/gpr_wb_queue_pkg.sv
// Shared types and constants for the GPR writeback queue: queued entry layout,
// drain FSM states and the load-byte data conditioning helper.
package gpr_wb_queue_pkg;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam logic [4:0] FLAG_REG_DEFAULT = 5'd30;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ovf;
    } entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FLAG = 1'b1
    } state_t;

    function automatic logic [31:0] lb_extend(input logic [31:0] data, input logic lb);
        return lb ? {{24{data[7]}}, data[7:0]} : data;
    endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order circular buffer of writeback entries. Every slot's address and
// overflow flag are exposed with a valid mask so the owner can scan for hazards.
module gpr_wb_fifo
    import gpr_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CW-1:0]    count,
    output logic [4:0]       entry_addr [DEPTH],
    output logic             entry_ovf  [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [AW-1:0] offs;
        assign offs            = AW'(gi) - rd_ptr_q;
        assign entry_valid[gi] = ({1'b0, offs} < count_q);
        assign entry_addr[gi]  = mem_q[gi].addr;
        assign entry_ovf[gi]   = mem_q[gi].ovf;
    end

endmodule

// File: rtl/gpr_wb_queue.sv
// Writeback queue feeding the GPR write port: buffers results, drains one write
// per cycle (plus a flag-register write after overflow results), reports hazards.
module gpr_wb_queue
    import gpr_wb_queue_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [4:0] FLAG_REG = FLAG_REG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     wb_lb,
    input  logic                     wb_ovf,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [4:0]               wr_addr,
    output logic [31:0]              wr_data,
    input  logic [4:0]               ra,
    input  logic [4:0]               rb,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    logic             push, pop;
    entry_t           push_entry, head;
    logic [CW-1:0]    count;
    logic [4:0]       entry_addr [DEPTH];
    logic             entry_ovf  [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    // Ready looks only at the registered count, so a same-cycle pop cannot reopen it.
    assign wb_ready   = (count < CW'(DEPTH));
    assign push       = wb_valid && wb_ready && (wb_addr != REG_ZERO);
    assign push_entry = '{addr: wb_addr, data: lb_extend(wb_data, wb_lb), ovf: wb_ovf};
    assign pop        = (state_q == S_IDLE) && !hold && (count != '0);

    gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_addr  (entry_addr),
        .entry_ovf   (entry_ovf),
        .entry_valid (entry_valid)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = head.addr;
                    wr_data_d = head.data;
                    state_d   = head.ovf ? S_FLAG : S_IDLE;
                end
            end
            S_FLAG: begin
                // Flag write follows its result unconditionally, even under hold.
                wr_en_d   = 1'b1;
                wr_addr_d = FLAG_REG;
                wr_data_d = 32'h1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign pending = count;

    logic match_a, match_b, flag_pending;

    always_comb begin
        match_a      = 1'b0;
        match_b      = 1'b0;
        flag_pending = (state_q == S_FLAG);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                if (entry_addr[i] == ra) match_a = 1'b1;
                if (entry_addr[i] == rb) match_b = 1'b1;
                if (entry_ovf[i])        flag_pending = 1'b1;
            end
        end
        if (wr_en_q && wr_addr_q == ra) match_a = 1'b1;
        if (wr_en_q && wr_addr_q == rb) match_b = 1'b1;
        busy_a = (ra != REG_ZERO) && (match_a || (ra == FLAG_REG && flag_pending));
        busy_b = (rb != REG_ZERO) && (match_b || (rb == FLAG_REG && flag_pending));
    end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed bench for gpr_wb_queue: walks the drain, load-byte, overflow-flag,
// full/hold, zero-register and asynchronous-reset cases with fixed expectations.
module tb_gpr_wb_queue;
    import gpr_wb_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_lb, wb_ovf, hold;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra, rb;
    logic        busy_a, busy_b;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_wb_queue #(.DEPTH(4), .FLAG_REG(5'd30)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_lb    (wb_lb),
        .wb_ovf   (wb_ovf),
        .hold     (hold),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ra       (ra),
        .rb       (rb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .pending  (pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s observed %h expected %h", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 32'(wr_en), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
            chk({tag, ".data"}, wr_data, d);
        end
    endtask

    task automatic offer(input logic [4:0] a, input logic [31:0] d, input logic lb, input logic ovf);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        wb_lb    = lb;
        wb_ovf   = ovf;
    endtask

    task automatic idle_in();
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        wb_lb    = 1'b0;
        wb_ovf   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        ra = '0;
        rb = '0;
        idle_in();
        #3;
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.wr_data", wr_data, 32'd0);
        chk("rst.ready", 32'(wb_ready), 32'd1);
        chk("rst.pending", 32'(pending), 32'd0);
        step();
        rst = 1'b0;

        // Single entry: write appears one edge after acceptance.
        ra = 5'd5;
        offer(5'd5, 32'h1234, 1'b0, 1'b0);
        step();
        idle_in();
        chk("t1.pending", 32'(pending), 32'd1);
        chk("t1.wr_en0", 32'(wr_en), 32'd0);
        chk("t1.busy_q", 32'(busy_a), 32'd1);
        step();
        chk_wr("t1.wr", 1'b1, 5'd5, 32'h1234);
        chk("t1.busy_wr", 32'(busy_a), 32'd1);
        chk("t1.pending0", 32'(pending), 32'd0);
        step();
        chk("t1.wr_off", 32'(wr_en), 32'd0);
        chk("t1.busy_off", 32'(busy_a), 32'd0);

        // Load-byte sign extension, negative then positive byte.
        offer(5'd6, 32'h000000F0, 1'b1, 1'b0);
        step();
        offer(5'd7, 32'h0000007F, 1'b1, 1'b0);
        step();
        idle_in();
        chk_wr("lb.neg", 1'b1, 5'd6, 32'hFFFFFFF0);
        step();
        chk_wr("lb.pos", 1'b1, 5'd7, 32'h0000007F);
        step();
        chk("lb.off", 32'(wr_en), 32'd0);

        // Overflow result expands into a flag write before the next entry.
        ra = 5'd30;
        offer(5'd8, 32'hFFFFFFFF, 1'b0, 1'b1);
        step();
        chk("ovf.busy_q", 32'(busy_a), 32'd1);
        offer(5'd9, 32'h2, 1'b0, 1'b0);
        step();
        idle_in();
        chk_wr("ovf.r8", 1'b1, 5'd8, 32'hFFFFFFFF);
        chk("ovf.busy_r8", 32'(busy_a), 32'd1);
        step();
        chk_wr("ovf.r30", 1'b1, 5'd30, 32'h1);
        chk("ovf.busy_fl", 32'(busy_a), 32'd1);
        step();
        chk_wr("ovf.r9", 1'b1, 5'd9, 32'h2);
        chk("ovf.busy_end", 32'(busy_a), 32'd0);
        step();
        chk("ovf.off", 32'(wr_en), 32'd0);

        // Fill under hold, then drain in order.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(5'(i), 32'(i * 16), 1'b0, 1'b0);
            step();
        end
        idle_in();
        chk("full.ready", 32'(wb_ready), 32'd0);
        chk("full.pending", 32'(pending), 32'd4);
        chk("full.wr_en", 32'(wr_en), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            ra = 5'(i);
            rb = 5'(i + 10);
            #1;
            chk($sformatf("full.busy_a%0d", i), 32'(busy_a), 32'd1);
            chk($sformatf("full.busy_b%0d", i), 32'(busy_b), 32'd0);
        end
        hold = 1'b0;
        offer(5'd12, 32'h99, 1'b0, 1'b0);
        step();
        idle_in();
        chk_wr("drain.r1", 1'b1, 5'd1, 32'd16);
        chk("drain.pending", 32'(pending), 32'd3);
        chk("drain.ready", 32'(wb_ready), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk_wr($sformatf("drain.r%0d", i), 1'b1, 5'(i), 32'(i * 16));
        end
        chk("drain.empty", 32'(pending), 32'd0);
        step();
        chk("drain.off", 32'(wr_en), 32'd0);
        step();
        chk("drain.no_r12", 32'(wr_en), 32'd0);

        // Register zero: handshake completes, nothing stored.
        ra = 5'd30;
        rb = 5'd0;
        offer(5'd0, 32'hDEAD, 1'b0, 1'b1);
        #1;
        chk("r0.ready", 32'(wb_ready), 32'd1);
        step();
        idle_in();
        chk("r0.pending", 32'(pending), 32'd0);
        chk("r0.busy_fl", 32'(busy_a), 32'd0);
        step();
        chk("r0.wr_en", 32'(wr_en), 32'd0);
        step();
        chk("r0.wr_en2", 32'(wr_en), 32'd0);

        // Asynchronous reset between a result write and its flag write.
        ra = 5'd30;
        rb = 5'd8;
        offer(5'd8, 32'hAA, 1'b0, 1'b1);
        step();
        idle_in();
        step();
        chk_wr("ar.r8", 1'b1, 5'd8, 32'hAA);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.wr_en", 32'(wr_en), 32'd0);
        chk("ar.wr_addr", 32'(wr_addr), 32'd0);
        chk("ar.pending", 32'(pending), 32'd0);
        chk("ar.busy_a", 32'(busy_a), 32'd0);
        chk("ar.busy_b", 32'(busy_b), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ar.no_flag", 32'(wr_en), 32'd0);
        step();
        chk("ar.no_flag2", 32'(wr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
